// File: rtl/bypass_net_ctrl_pkg.sv
// bypass_pkg: shared FSM/source encodings and default widths for bypass_net_ctrl.
package bypass_pkg;
    localparam int DATA_W_D    = 32;
    localparam int ADDR_W_D    = 5;
    localparam int N_RD_D      = 2;
    localparam int MUL_DEPTH_D = 5;
    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
    typedef enum logic [2:0] {NONE, EXE, MUL, FILL, CACHE, WB} src_t;
endpackage

// File: rtl/bypass_net_ctrl_if.sv
// bypass_net_ctrl_if: producer/consumer signals of the bypass controller.
interface bypass_net_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_RD   = 2
);
    logic [N_RD*ADDR_W-1:0] rd_addr_i;
    logic [N_RD-1:0]        rd_used_i;
    logic [DATA_W-1:0]      exe_data_i;
    logic [ADDR_W-1:0]      exe_addr_i;
    logic                   exe_wr_en_i;
    logic                   mul_issue_en_i;
    logic [ADDR_W-1:0]      mul_issue_addr_i;
    logic [DATA_W-1:0]      mul_data_i;
    logic [DATA_W-1:0]      cache_data_i;
    logic [ADDR_W-1:0]      cache_addr_i;
    logic                   cache_wr_en_i;
    logic                   tl_hit_i;
    logic                   fill_valid_i;
    logic [DATA_W-1:0]      fill_data_i;
    logic [DATA_W-1:0]      wb_data_i;
    logic [ADDR_W-1:0]      wb_addr_i;
    logic                   wb_en_i;
    logic [N_RD-1:0]        bypass_en_o;
    logic [N_RD*DATA_W-1:0] bypass_data_o;
    logic                   stall_core_o;
    modport master (
        output rd_addr_i, rd_used_i, exe_data_i, exe_addr_i, exe_wr_en_i,
               mul_issue_en_i, mul_issue_addr_i, mul_data_i,
               cache_data_i, cache_addr_i, cache_wr_en_i, tl_hit_i,
               fill_valid_i, fill_data_i, wb_data_i, wb_addr_i, wb_en_i,
        input  bypass_en_o, bypass_data_o, stall_core_o
    );
    modport slave (
        input  rd_addr_i, rd_used_i, exe_data_i, exe_addr_i, exe_wr_en_i,
               mul_issue_en_i, mul_issue_addr_i, mul_data_i,
               cache_data_i, cache_addr_i, cache_wr_en_i, tl_hit_i,
               fill_valid_i, fill_data_i, wb_data_i, wb_addr_i, wb_en_i,
        output bypass_en_o, bypass_data_o, stall_core_o
    );
endinterface

// File: rtl/bypass_port_sel.sv
// bypass_port_sel: youngest-first source selection and hazard detection for one read port.
module bypass_port_sel
    import bypass_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int MUL_DEPTH = MUL_DEPTH_D
) (
    input  logic [ADDR_W-1:0]                a,
    input  logic                             used,
    input  logic                             exe_en,
    input  logic [ADDR_W-1:0]                exe_addr,
    input  logic [DATA_W-1:0]                exe_data,
    input  logic [MUL_DEPTH-1:0]             sb_valid,
    input  logic [MUL_DEPTH-1:0][ADDR_W-1:0] sb_addr,
    input  logic [DATA_W-1:0]                mul_data,
    input  logic                             fill_en,
    input  logic [ADDR_W-1:0]                miss_addr,
    input  logic [DATA_W-1:0]                fill_data,
    input  logic                             cache_en,
    input  logic                             tl_hit,
    input  logic                             idle,
    input  logic [ADDR_W-1:0]                cache_addr,
    input  logic [DATA_W-1:0]                cache_data,
    input  logic                             wb_en,
    input  logic [ADDR_W-1:0]                wb_addr,
    input  logic [DATA_W-1:0]                wb_data,
    output logic                             en,
    output logic [DATA_W-1:0]                data,
    output logic                             stall
);
    logic elig, exe_hit, mul_hit, fill_hit, cache_hit, wb_hit, in_flight;
    src_t src;
    always_comb begin
        elig      = used && a != '0;
        exe_hit   = exe_en && exe_addr == a;
        mul_hit   = sb_valid[MUL_DEPTH-1] && sb_addr[MUL_DEPTH-1] == a;
        fill_hit  = fill_en && miss_addr == a;
        cache_hit = cache_en && tl_hit && cache_addr == a;
        wb_hit    = wb_en && wb_addr == a;
        in_flight = 1'b0;
        for (int j = 0; j < MUL_DEPTH - 1; j++)
            in_flight = in_flight | (sb_valid[j] && sb_addr[j] == a);
        src = !elig    ? NONE  :
              exe_hit  ? EXE   :
              mul_hit  ? MUL   :
              fill_hit ? FILL  :
              cache_hit? CACHE :
              wb_hit   ? WB    : NONE;
        en   = src != NONE;
        data = src == EXE   ? exe_data   :
               src == MUL   ? mul_data   :
               src == FILL  ? fill_data  :
               src == CACHE ? cache_data :
               src == WB    ? wb_data    : '0;
        // a multiply result still in flight is only harmless if EXE already overrides it
        stall = elig && ((in_flight && !exe_hit) ||
                         (cache_en && !tl_hit && idle && cache_addr == a));
    end
endmodule

// File: rtl/bypass_net_ctrl.sv
// bypass_net_ctrl: operand forwarding, multiply scoreboard and cache-miss stall control.
// Optional BYPASS_STATS_EN adds saturating stall/bypass cycle counters.
module bypass_net_ctrl
    import bypass_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int N_RD      = N_RD_D,
    parameter int MUL_DEPTH = MUL_DEPTH_D
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    bypass_net_ctrl_if.slave   bus
`ifdef BYPASS_STATS_EN
    ,
    output logic [31:0]        stat_stall_cnt_o,
    output logic [31:0]        stat_bypass_cnt_o
`endif
);
    logic [MUL_DEPTH-1:0]             sb_valid;
    logic [MUL_DEPTH-1:0][ADDR_W-1:0] sb_addr;
    state_t                           state, state_nxt;
    logic [ADDR_W-1:0]                miss_addr, miss_addr_nxt;
    logic                             miss_start, stall_raw;
    logic [N_RD-1:0]                  en_raw, port_stall;
    logic [N_RD*DATA_W-1:0]           data_raw;
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            sb_valid  <= '0;
            sb_addr   <= '0;
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            sb_valid  <= {sb_valid[MUL_DEPTH-2:0], bus.mul_issue_en_i};
            sb_addr   <= {sb_addr[MUL_DEPTH-2:0], bus.mul_issue_addr_i};
            state     <= state_nxt;
            miss_addr <= miss_addr_nxt;
        end
    end
    always_comb begin
        miss_start    = state == IDLE && bus.cache_wr_en_i && !bus.tl_hit_i;
        state_nxt     = miss_start ? MISS :
                        (state == MISS && bus.fill_valid_i) ? IDLE : state;
        miss_addr_nxt = miss_start ? bus.cache_addr_i : miss_addr;
    end
    for (genvar p = 0; p < N_RD; p++) begin : g_port
        bypass_port_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MUL_DEPTH(MUL_DEPTH)) u_sel (
            .a          (bus.rd_addr_i[p*ADDR_W +: ADDR_W]),
            .used       (bus.rd_used_i[p]),
            .exe_en     (bus.exe_wr_en_i),
            .exe_addr   (bus.exe_addr_i),
            .exe_data   (bus.exe_data_i),
            .sb_valid   (sb_valid),
            .sb_addr    (sb_addr),
            .mul_data   (bus.mul_data_i),
            .fill_en    (state == MISS && bus.fill_valid_i),
            .miss_addr  (miss_addr),
            .fill_data  (bus.fill_data_i),
            .cache_en   (bus.cache_wr_en_i),
            .tl_hit     (bus.tl_hit_i),
            .idle       (state == IDLE),
            .cache_addr (bus.cache_addr_i),
            .cache_data (bus.cache_data_i),
            .wb_en      (bus.wb_en_i),
            .wb_addr    (bus.wb_addr_i),
            .wb_data    (bus.wb_data_i),
            .en         (en_raw[p]),
            .data       (data_raw[p*DATA_W +: DATA_W]),
            .stall      (port_stall[p])
        );
    end
    // outputs are held at zero for the whole reset window, not just after the edge
    always_comb begin
        stall_raw         = |port_stall || miss_start || (state == MISS && !bus.fill_valid_i);
        bus.stall_core_o  = rsn_i && stall_raw;
        bus.bypass_en_o   = rsn_i ? en_raw : '0;
        bus.bypass_data_o = rsn_i ? data_raw : '0;
    end
`ifdef BYPASS_STATS_EN
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            stat_stall_cnt_o  <= '0;
            stat_bypass_cnt_o <= '0;
        end else begin
            if (stall_raw && !(&stat_stall_cnt_o))
                stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
            if (|en_raw && !stall_raw && !(&stat_bypass_cnt_o))
                stat_bypass_cnt_o <= stat_bypass_cnt_o + 32'd1;
        end
    end
`endif
endmodule
